if_debug_ctrl: RTL
==================

// Module: if_debug_ctrl
// PURPOSE
//  Breakpoint/run-control sequencer for the IF stage. Compares the fetch PC with
//  programmable PC breakpoints and a host halt request. Drives the IF stage's
//  stall_breakpoint/continue_en pair to freeze the PC and IF/ID register, to resume,
//  or to single/multi-step. Sits between the debug host interface and if_stage.
// PARAMETERS
//  NUM_BP   4   number of PC breakpoint slots (power of 2, >=2)
//  STEP_W   8   width of the step counter
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        asynchronous active-low reset
//  if_pc        in   32       current fetch PC of the IF stage
//  stall        in   1        pipeline hazard stall (same signal fed to if_stage)
//  bp_wr_en     in   1        write breakpoint slot this cycle
//  bp_wr_idx    in   log2(NUM_BP)  slot index
//  bp_wr_addr   in   32       breakpoint PC (bits [1:0] ignored in compare)
//  bp_wr_valid  in   1        slot enable written with the address
//  halt_req     in   1        host halt pulse
//  run_req      in   1        host resume pulse (valid in HALT only)
//  step_req     in   1        host step pulse (valid in HALT only)
//  step_num     in   STEP_W   instructions to step; 0 is treated as 1
//  stall_breakpoint out 1     freeze request to if_stage
//  continue_en  out  1        one-advance permit to if_stage
//  halted       out  1        state==HALT
//  hit_valid    out  1        sticky: last halt caused by a breakpoint
//  hit_idx      out  log2(NUM_BP)  slot of the last breakpoint hit
//  halt_pc      out  32       if_pc latched on entry to HALT
// BEHAVIOUR
//  Reset: state RUN, all slots invalid, skip_valid=0, step_cnt=0, every output 0.
//  States: RUN, HALT, STEP. Breakpoint regs write on clk when bp_wr_en, in any state.
//  match = some valid slot i with bp_addr[i][31:2]==if_pc[31:2], and not
//    (skip_valid && if_pc==skip_pc). Lowest index wins for hit_idx.
//  stall_breakpoint = (state!=RUN) | (state==RUN & (match|halt_req)); combinational,
//    so the PC freezes on the breakpoint instruction itself (zero-cycle latency).
//  continue_en = (state==STEP); combinational from state.
//  RUN:  match|halt_req -> HALT; halt_pc<=if_pc; hit_valid<=match, hit_idx<=idx
//        (halt_req with match: hit recorded). skip_valid clears once if_pc!=skip_pc.
//  HALT: run_req -> RUN, skip_pc<=if_pc, skip_valid<=1 (no re-hit at same PC).
//        step_req -> STEP, step_cnt<=max(step_num,1). run_req beats step_req.
//  STEP: each cycle with stall==0 is one advance: step_cnt-=1; reaching 0 ->
//        HALT, halt_pc<=next if_pc, hit_valid<=0. stall==1 cycles do not count.
//        Breakpoint matches are ignored in STEP. halt_req -> HALT immediately.
//  halt_req in HALT, run_req/step_req in RUN or STEP: ignored.
//  bp_wr to a slot matching the current PC takes effect next cycle.
//  Async reset mid-STEP or mid-HALT returns to RUN with outputs 0 in that
//  cycle, independent of clk.
// TESTING
//  1 slot0=0x10 valid, free run from 0 -> stall_breakpoint high while if_pc=0x10,
//    halted=1 next edge, halt_pc=0x10, hit_valid=1, hit_idx=0.
//  2 From (1) run_req -> RUN, PC passes 0x10 without re-halt; loop back to 0x10
//    later -> halts again.
//  3 HALT at 0x20, step_num=3, stall high for 2 cycles mid-step -> continue_en high
//    5 cycles, halted again with halt_pc=0x2C, hit_valid=0.
//  4 Slots 1 and 3 both =0x40 -> hit_idx=1; halt_req same cycle -> single halt.
//  5 halt_req during STEP with step_cnt=5 -> HALT next edge, continue_en drops.
//  6 Assert rst_n low mid-STEP off a clock edge -> outputs 0 at once, slots cleared,
//    free run resumes.

Source files
------------

// File: rtl/if_debug_ctrl.sv
// Breakpoint/run-control sequencer for the IF stage: PC breakpoints, host halt, run and step.
// Freeze request is combinational (zero-cycle); state, hit info and halt_pc update on the next clk edge.
module if_debug_ctrl #(
    parameter int NUM_BP = 4,
    parameter int STEP_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               if_pc,
    input  logic                      stall,
    input  logic                      bp_wr_en,
    input  logic [$clog2(NUM_BP)-1:0] bp_wr_idx,
    input  logic [31:0]               bp_wr_addr,
    input  logic                      bp_wr_valid,
    input  logic                      halt_req,
    input  logic                      run_req,
    input  logic                      step_req,
    input  logic [STEP_W-1:0]         step_num,
    output logic                      stall_breakpoint,
    output logic                      continue_en,
    output logic                      halted,
    output logic                      hit_valid,
    output logic [$clog2(NUM_BP)-1:0] hit_idx,
    output logic [31:0]               halt_pc
);
    localparam int IDX_W = $clog2(NUM_BP);

    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_STEP} state_t;

    state_t                     state_q, state_d;
    logic [NUM_BP-1:0][31:0]    bp_addr_q;
    logic [NUM_BP-1:0]          bp_vld_q;
    logic [31:0]                skip_pc_q, skip_pc_d;
    logic                       skip_vld_q, skip_vld_d;
    logic [STEP_W-1:0]          step_cnt_q, step_cnt_d;
    logic [31:0]                halt_pc_q, halt_pc_d;
    logic                       cap_q, cap_d;
    logic                       hit_vld_q, hit_vld_d;
    logic [IDX_W-1:0]           hit_idx_q, hit_idx_d;

    logic                       found;
    logic [IDX_W-1:0]           hit_sel;
    logic                       match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_addr_q <= '0;
            bp_vld_q  <= '0;
        end else if (bp_wr_en) begin
            bp_addr_q[bp_wr_idx] <= bp_wr_addr;
            bp_vld_q[bp_wr_idx]  <= bp_wr_valid;
        end
    end

    // Lowest valid slot wins; word-address compare ignores byte offset bits.
    always_comb begin
        found   = 1'b0;
        hit_sel = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (!found && bp_vld_q[i] &&
                ((bp_addr_q[i] & ~32'h3) == (if_pc & ~32'h3))) begin
                found   = 1'b1;
                hit_sel = IDX_W'(i);
            end
        end
    end

    assign match = found && !(skip_vld_q && (if_pc == skip_pc_q));

    always_comb begin
        state_d    = state_q;
        skip_pc_d  = skip_pc_q;
        skip_vld_d = skip_vld_q;
        step_cnt_d = step_cnt_q;
        halt_pc_d  = cap_q ? if_pc : halt_pc_q;
        cap_d      = 1'b0;
        hit_vld_d  = hit_vld_q;
        hit_idx_d  = hit_idx_q;
        case (state_q)
            ST_RUN: begin
                if (skip_vld_q && (if_pc != skip_pc_q))
                    skip_vld_d = 1'b0;
                if (match || halt_req) begin
                    state_d   = ST_HALT;
                    halt_pc_d = if_pc;
                    hit_vld_d = match;
                    if (match)
                        hit_idx_d = hit_sel;
                end
            end
            ST_HALT: begin
                if (run_req) begin
                    state_d    = ST_RUN;
                    skip_pc_d  = if_pc;
                    skip_vld_d = 1'b1;
                end else if (step_req) begin
                    state_d    = ST_STEP;
                    step_cnt_d = (step_num == '0) ? STEP_W'(1) : step_num;
                end
            end
            ST_STEP: begin
                // halt_pc is the PC after the final advance, so it is captured one edge later.
                if (halt_req) begin
                    state_d   = ST_HALT;
                    cap_d     = 1'b1;
                    hit_vld_d = 1'b0;
                end else if (!stall) begin
                    step_cnt_d = step_cnt_q - STEP_W'(1);
                    if (step_cnt_q == STEP_W'(1)) begin
                        state_d   = ST_HALT;
                        cap_d     = 1'b1;
                        hit_vld_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            skip_pc_q  <= '0;
            skip_vld_q <= 1'b0;
            step_cnt_q <= '0;
            halt_pc_q  <= '0;
            cap_q      <= 1'b0;
            hit_vld_q  <= 1'b0;
            hit_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            skip_pc_q  <= skip_pc_d;
            skip_vld_q <= skip_vld_d;
            step_cnt_q <= step_cnt_d;
            halt_pc_q  <= halt_pc_d;
            cap_q      <= cap_d;
            hit_vld_q  <= hit_vld_d;
            hit_idx_q  <= hit_idx_d;
        end
    end

    assign stall_breakpoint = (state_q != ST_RUN) || match || halt_req;
    assign continue_en      = (state_q == ST_STEP);
    assign halted           = (state_q == ST_HALT);
    assign hit_valid        = hit_vld_q;
    assign hit_idx          = hit_idx_q;
    assign halt_pc          = cap_q ? if_pc : halt_pc_q;
endmodule
